// File: rtl/bsk_prm_pkg.sv
// Shared definitions for the BSK PRM relay path: channel count, counter
// width, the per-channel FSM state type and a population-count helper.
package bsk_prm_pkg;

    localparam int COM_NUM   = 16;
    localparam int CNT_W     = 16;
    localparam int COM_CNT_W = $clog2(COM_NUM + 1);

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ON_CHK  = 2'd1,
        ON      = 2'd2,
        OFF_CHK = 2'd3
    } com_state_t;

    // Number of set bits in a channel vector (0..COM_NUM)
    function automatic logic [COM_CNT_W-1:0] popCount(input logic [COM_NUM-1:0] vec);
        logic [COM_CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < COM_NUM; i++) begin
            sum = sum + COM_CNT_W'(vec[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/bsk_com_channel.sv
// One relay channel: debounced turn-on, minimum on-time, debounced release,
// and an immediate forced drop. relay is active-low and registered.
// onNext flags that the state being entered is ON or OFF_CHK, so the parent
// can register its energised-channel count on the same edge as relay.
module bsk_com_channel
    import bsk_prm_pkg::*;
#(
    parameter int DEB_ON  = 8,
    parameter int DEB_OFF = 8,
    parameter int MIN_ON  = 100
)
(
    input  logic iClk,
    input  logic iRes,
    input  logic req,
    input  logic force_off,
    output logic relay,
    output logic onNext
);

    localparam logic [CNT_W-1:0] DEB_ON_C  = CNT_W'(DEB_ON);
    localparam logic [CNT_W-1:0] DEB_OFF_C = CNT_W'(DEB_OFF);
    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    // ON is entered with cnt=0, so after k edges in ON the counter holds k;
    // the release is allowed on the edge where the held value is MIN_ON-1.
    localparam logic [CNT_W-1:0] MIN_ON_M1 = CNT_W'(MIN_ON - 1);

    com_state_t       stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext, cntInc;

    assign cntInc = cntReg + CNT_W'(1);

    // Next-state and counter logic; forced drop overrides every transition
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        if (force_off) begin
            stateNext = OFF;
            cntNext   = '0;
        end else begin
            case (stateReg)
                OFF: begin
                    if (req) begin
                        if (DEB_ON == 1) begin
                            stateNext = ON;
                            cntNext   = '0;
                        end else begin
                            stateNext = ON_CHK;
                            cntNext   = CNT_W'(1);
                        end
                    end
                end
                ON_CHK: begin
                    if (!req) begin
                        stateNext = OFF;
                        cntNext   = '0;
                    end else if (cntInc == DEB_ON_C) begin
                        stateNext = ON;
                        cntNext   = '0;
                    end else begin
                        cntNext = cntInc;
                    end
                end
                ON: begin
                    if (!req && (cntReg >= MIN_ON_M1)) begin
                        if (DEB_OFF == 1) begin
                            stateNext = OFF;
                            cntNext   = '0;
                        end else begin
                            stateNext = OFF_CHK;
                            cntNext   = CNT_W'(1);
                        end
                    end else if (cntReg < MIN_ON_C) begin
                        cntNext = cntInc;
                    end
                end
                OFF_CHK: begin
                    if (req) begin
                        // Minimum on-time was already served; keep it satisfied
                        stateNext = ON;
                        cntNext   = MIN_ON_C;
                    end else if (cntInc == DEB_OFF_C) begin
                        stateNext = OFF;
                        cntNext   = '0;
                    end else begin
                        cntNext = cntInc;
                    end
                end
                default: begin
                    stateNext = OFF;
                    cntNext   = '0;
                end
            endcase
        end
    end

    assign onNext = (stateNext == ON) || (stateNext == OFF_CHK);

    // State, counter and relay drive registers
    always_ff @(posedge iClk or negedge iRes) begin
        if (!iRes) begin
            stateReg <= OFF;
            cntReg   <= '0;
            relay    <= 1'b1;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            relay    <= ~onNext;
        end
    end

endmodule

// File: rtl/bsk_com_relay_filter.sv
// BSK relay output filter: 16 debounced relay channels driven from the
// register block's active-low commands and terminal-block enable.
// Build option BSK_COM_FILTER_SYNC_EN adds a 2-flop synchroniser on every
// input; leave it undefined when iCom/iEnable already come from iClk.
module bsk_com_relay_filter
    import bsk_prm_pkg::*;
#(
    parameter int DEB_ON  = 8,
    parameter int DEB_OFF = 8,
    parameter int MIN_ON  = 100
)
(
    input  logic                 iClk,
    input  logic                 iRes,
    input  logic [COM_NUM-1:0]   iCom,
    input  logic                 iEnable,
    output logic [COM_NUM-1:0]   oRelay,
    output logic [COM_CNT_W-1:0] oCnt
);

    logic [COM_NUM-1:0] comSync;
    logic               enableSync;
    logic [COM_NUM-1:0] req;
    logic [COM_NUM-1:0] onNext;

`ifdef BSK_COM_FILTER_SYNC_EN
    logic [COM_NUM-1:0] comMeta;
    logic               enableMeta;

    // Two-stage synchroniser, idles inactive (high) out of reset
    always_ff @(posedge iClk or negedge iRes) begin
        if (!iRes) begin
            comMeta    <= '1;
            comSync    <= '1;
            enableMeta <= 1'b1;
            enableSync <= 1'b1;
        end else begin
            comMeta    <= iCom;
            comSync    <= comMeta;
            enableMeta <= iEnable;
            enableSync <= enableMeta;
        end
    end
`else
    assign comSync    = iCom;
    assign enableSync = iEnable;
`endif

    assign req = ~comSync & {COM_NUM{~enableSync}};

    generate
        for (genvar gi = 0; gi < COM_NUM; gi++) begin : gen_channel
            bsk_com_channel #(
                .DEB_ON  (DEB_ON),
                .DEB_OFF (DEB_OFF),
                .MIN_ON  (MIN_ON)
            ) uChannel (
                .iClk      (iClk),
                .iRes      (iRes),
                .req       (req[gi]),
                .force_off (enableSync),
                .relay     (oRelay[gi]),
                .onNext    (onNext[gi])
            );
        end
    endgenerate

    // Energised-channel count, aligned with the relay registers
    always_ff @(posedge iClk or negedge iRes) begin
        if (!iRes) begin
            oCnt <= '0;
        end else begin
            oCnt <= popCount(onNext);
        end
    end

endmodule

// File: tb/tb_bsk_com_relay_filter.sv
// Self-checking bench for bsk_com_relay_filter (DEB_ON=4, DEB_OFF=3, MIN_ON=10).
// Expected relay/count values are queued per edge as stimulus is applied and
// compared when that edge has been sampled. Works with or without
// BSK_COM_FILTER_SYNC_EN defined.
module tb_bsk_com_relay_filter;

    localparam int DEB_ON  = 4;
    localparam int DEB_OFF = 3;
    localparam int MIN_ON  = 10;
`ifdef BSK_COM_FILTER_SYNC_EN
    localparam int SLAT = 3;
`else
    localparam int SLAT = 1;
`endif
    localparam int TON = SLAT + DEB_ON - 1;

    logic        iClk = 1'b0;
    logic        iRes = 1'b0;
    logic [15:0] iCom = 16'hFFFF;
    logic        iEnable = 1'b1;
    logic [15:0] oRelay;
    logic [4:0]  oCnt;

    typedef struct {
        int          edgeNo;
        logic [15:0] relay;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int edgeCnt = 0;
    int checks  = 0;
    int fails   = 0;

    bsk_com_relay_filter #(
        .DEB_ON  (DEB_ON),
        .DEB_OFF (DEB_OFF),
        .MIN_ON  (MIN_ON)
    ) dut (
        .iClk    (iClk),
        .iRes    (iRes),
        .iCom    (iCom),
        .iEnable (iEnable),
        .oRelay  (oRelay),
        .oCnt    (oCnt)
    );

    always #5 iClk = ~iClk;

    task automatic tick;
        @(posedge iClk);
        #1;
        edgeCnt++;
    endtask

    task automatic push_exp(input int edgeNo, input logic [15:0] r, input logic [4:0] c);
        sb.push_back('{edgeNo, r, c});
    endtask

    task automatic test_reset;
        iRes = 1'b0;
        iEnable = 1'b0;
        iCom = 16'h1234;
        repeat (3) tick();
        checks++;
        if (oRelay !== 16'hFFFF || oCnt !== 5'd0) begin
            fails++;
            $display("FAIL reset_hold: oRelay=%h oCnt=%0d, expected oRelay=ffff oCnt=0", oRelay, oCnt);
        end else $display("reset_hold: oRelay=%h oCnt=%0d", oRelay, oCnt);
        iCom = 16'hFFFF;
        iRes = 1'b1;
        repeat (SLAT + 2) tick();
        checks++;
        if (oRelay !== 16'hFFFF || oCnt !== 5'd0) begin
            fails++;
            $display("FAIL reset_idle: oRelay=%h oCnt=%0d, expected oRelay=ffff oCnt=0", oRelay, oCnt);
        end else $display("reset_idle: oRelay=%h oCnt=%0d", oRelay, oCnt);
    endtask

    task automatic test_turn_on;
        int base;
        exp_t e;
        base = edgeCnt;
        iCom = 16'hFFFE;
        for (int k = 1; k < TON; k++) push_exp(base + k, 16'hFFFF, 5'd0);
        push_exp(base + TON, 16'hFFFE, 5'd1);
        for (int k = 1; k <= TON; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edgeNo == edgeCnt) begin
                e = sb.pop_front();
                checks++;
                if (oRelay !== e.relay || oCnt !== e.cnt) begin
                    fails++;
                    $display("FAIL turn_on edge+%0d: oRelay=%h oCnt=%0d, expected oRelay=%h oCnt=%0d", k, oRelay, oCnt, e.relay, e.cnt);
                end else $display("turn_on edge+%0d: oRelay=%h oCnt=%0d", k, oRelay, oCnt);
            end
        end
    endtask

    // Continues from test_turn_on: channel 0 energised at the current edge
    task automatic test_min_on;
        int base;
        exp_t e;
        base = edgeCnt;
        for (int k = 1; k <= MIN_ON + DEB_OFF - 2; k++) push_exp(base + k, 16'hFFFE, 5'd1);
        push_exp(base + MIN_ON + DEB_OFF - 1, 16'hFFFF, 5'd0);
        for (int k = 1; k <= MIN_ON + DEB_OFF - 1; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edgeNo == edgeCnt) begin
                e = sb.pop_front();
                checks++;
                if (oRelay !== e.relay || oCnt !== e.cnt) begin
                    fails++;
                    $display("FAIL min_on E+%0d: oRelay=%h oCnt=%0d, expected oRelay=%h oCnt=%0d", k, oRelay, oCnt, e.relay, e.cnt);
                end else $display("min_on E+%0d: oRelay=%h oCnt=%0d", k, oRelay, oCnt);
            end
            if (k == 2) iCom = 16'hFFFF;
        end
    endtask

    task automatic test_glitch;
        int base;
        exp_t e;
        base = edgeCnt;
        iCom = 16'hFFFD;
        for (int k = 1; k <= SLAT + 6; k++) push_exp(base + k, 16'hFFFF, 5'd0);
        for (int k = 1; k <= SLAT + 6; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edgeNo == edgeCnt) begin
                e = sb.pop_front();
                checks++;
                if (oRelay !== e.relay || oCnt !== e.cnt) begin
                    fails++;
                    $display("FAIL glitch edge+%0d: oRelay=%h oCnt=%0d, expected oRelay=%h oCnt=%0d", k, oRelay, oCnt, e.relay, e.cnt);
                end else $display("glitch edge+%0d: oRelay=%h oCnt=%0d", k, oRelay, oCnt);
            end
            if (k == 3) iCom = 16'hFFFF;
        end
    endtask

    // Release starts at E; one request sample at E+11 (inside the release
    // window) returns to ON; request drops again at E+12, so release is E+14.
    task automatic test_retrigger;
        int base;
        exp_t e;
        base = edgeCnt;
        iCom = 16'hFFFE;
        for (int k = 1; k < TON; k++) push_exp(base + k, 16'hFFFF, 5'd0);
        for (int k = TON; k <= TON + 13; k++) push_exp(base + k, 16'hFFFE, 5'd1);
        push_exp(base + TON + 14, 16'hFFFF, 5'd0);
        for (int k = 1; k <= TON + 14; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edgeNo == edgeCnt) begin
                e = sb.pop_front();
                checks++;
                if (oRelay !== e.relay || oCnt !== e.cnt) begin
                    fails++;
                    $display("FAIL retrigger edge+%0d: oRelay=%h oCnt=%0d, expected oRelay=%h oCnt=%0d", k, oRelay, oCnt, e.relay, e.cnt);
                end else $display("retrigger edge+%0d: oRelay=%h oCnt=%0d", k, oRelay, oCnt);
            end
            if (k == TON) iCom = 16'hFFFF;
            if (k == TON + 11 - SLAT) iCom = 16'hFFFE;
            if (k == TON + 12 - SLAT) iCom = 16'hFFFF;
        end
    endtask

    task automatic test_safety;
        int base;
        int last;
        exp_t e;
        base = edgeCnt;
        last = TON + 2 * SLAT + 4;
        iCom = 16'h0000;
        for (int k = 1; k < TON; k++) push_exp(base + k, 16'hFFFF, 5'd0);
        for (int k = TON; k < TON + SLAT; k++) push_exp(base + k, 16'h0000, 5'd16);
        for (int k = TON + SLAT; k <= last; k++) push_exp(base + k, 16'hFFFF, 5'd0);
        for (int k = 1; k <= last; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edgeNo == edgeCnt) begin
                e = sb.pop_front();
                checks++;
                if (oRelay !== e.relay || oCnt !== e.cnt) begin
                    fails++;
                    $display("FAIL safety edge+%0d: oRelay=%h oCnt=%0d, expected oRelay=%h oCnt=%0d", k, oRelay, oCnt, e.relay, e.cnt);
                end else $display("safety edge+%0d: oRelay=%h oCnt=%0d", k, oRelay, oCnt);
            end
            if (k == TON) iEnable = 1'b1;
            if (k == TON + SLAT + 2) begin
                iCom = 16'hFFFF;
                iEnable = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        exp_t e;
        base = edgeCnt;
        iCom = 16'h0000;
        for (int k = 1; k < TON; k++) push_exp(base + k, 16'hFFFF, 5'd0);
        push_exp(base + TON, 16'h0000, 5'd16);
        for (int k = 1; k <= TON; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edgeNo == edgeCnt) begin
                e = sb.pop_front();
                checks++;
                if (oRelay !== e.relay || oCnt !== e.cnt) begin
                    fails++;
                    $display("FAIL reset_mid_on edge+%0d: oRelay=%h oCnt=%0d, expected oRelay=%h oCnt=%0d", k, oRelay, oCnt, e.relay, e.cnt);
                end else $display("reset_mid_on edge+%0d: oRelay=%h oCnt=%0d", k, oRelay, oCnt);
            end
        end
        #2;
        iRes = 1'b0;
        #1;
        checks++;
        if (oRelay !== 16'hFFFF || oCnt !== 5'd0) begin
            fails++;
            $display("FAIL reset_async: oRelay=%h oCnt=%0d, expected oRelay=ffff oCnt=0", oRelay, oCnt);
        end else $display("reset_async: oRelay=%h oCnt=%0d", oRelay, oCnt);
        iCom = 16'hFFFF;
        repeat (2) tick();
        iRes = 1'b1;
        repeat (SLAT + 3) tick();
        checks++;
        if (oRelay !== 16'hFFFF || oCnt !== 5'd0) begin
            fails++;
            $display("FAIL reset_recover: oRelay=%h oCnt=%0d, expected oRelay=ffff oCnt=0", oRelay, oCnt);
        end else $display("reset_recover: oRelay=%h oCnt=%0d", oRelay, oCnt);
    endtask

    initial begin
        test_reset();
        test_turn_on();
        test_min_on();
        test_glitch();
        test_retrigger();
        test_safety();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bsk_com_relay_filter.md
Name: bsk_com_relay_filter

Overview:
- Downstream stage of the BSK PRM register block.
- Consumes the 16 validated active-low commands (oCom) and the terminal-block enable (oEnable) produced by that block.
- Drives the 16 relay outputs with input synchronisation, on/off debounce, a minimum relay-on time, and an immediate safety drop on loss of enable.
- Also reports how many relays are currently energised.

Parameters:
- DEB_ON, 8: consecutive active samples required to energise a relay (1..65535).
- DEB_OFF, 8: consecutive inactive samples required to release a relay (1..65535).
- MIN_ON, 100: minimum clocks a relay stays energised after turn-on (1..65535).

Ports:
- iClk  in  1  system clock.
- iRes  in  1  reset, asynchronous, active-low.
- iCom  in  16  commands from the register block, active 0.
- iEnable  in  1  terminal-block enable from the register block, active 0.
- oRelay  out  16  relay drive, active 0.
- oCnt  out  5  number of channels in state ON or OFF_CHK (0..16).

Behaviour:
- Clocking and reset: one clock, iClk. Reset iRes is asynchronous and active-low.
- Reset values: oRelay=16'hFFFF, oCnt=0, all channel FSMs in OFF, all counters 0, synchroniser flops 1 (inactive).
- Request: req[i] = ~iCom_s[i] & ~iEnable_s, where _s denotes the synchronised input.
- Sample edge S: the first rising edge at which a channel FSM sees a changed input.
  - With BSK_COM_FILTER_SYNC_EN: S = 3rd edge after the input change.
  - Without it: S = 1st edge after the input change.
- Per-channel FSM states: OFF, ON_CHK, ON, OFF_CHK. Each channel has one 16-bit counter.
- OFF (oRelay[i]=1):
  - req=1 -> ON_CHK with cnt=1.
  - If DEB_ON==1, go directly to ON instead.
- ON_CHK (oRelay[i]=1):
  - req=0 -> OFF.
  - req=1 and cnt+1==DEB_ON -> ON.
  - Otherwise cnt++.
  - Result: oRelay[i] falls at edge S+DEB_ON-1.
- ON (oRelay[i]=0): entered at edge E, cnt cleared; cnt saturates at MIN_ON.
  - At edge E+k with k>=MIN_ON and req=0 -> OFF_CHK with cnt=1.
  - If DEB_OFF==1, go directly to OFF instead.
  - req=0 before MIN_ON has elapsed has no effect; the channel stays ON.
- OFF_CHK (oRelay[i]=0):
  - req=1 -> ON. Min-on is already satisfied, so cnt stays saturated at MIN_ON.
  - req=0 and cnt+1==DEB_OFF -> OFF.
  - Otherwise cnt++.
  - If req is already low at E+MIN_ON, the relay releases at edge E+MIN_ON+DEB_OFF-1.
- Safety drop: iEnable_s=1 forces every channel to OFF and oRelay=16'hFFFF on that same edge S. This bypasses MIN_ON and DEB_OFF and has priority over all transitions.
- oCnt: registered population count of channels whose next state is ON or OFF_CHK. It updates on the same edge as oRelay. Width is 5 bits; the value never exceeds 16.
- oRelay is registered. No combinational path exists from iCom to oRelay.
- Simultaneous rise and fall on different channels are independent.
- A glitch shorter than DEB_ON samples never reaches oRelay.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). It does not wait for MIN_ON.

Optional Feature:
- Macro: BSK_COM_FILTER_SYNC_EN.
- Defined: a 2-flop synchroniser on each of the 17 inputs (iCom, iEnable); S = 3rd edge.
- Undefined: the inputs feed the FSMs directly, for use when the source is already in the iClk domain; S = 1st edge.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package bsk_prm_pkg:
  - COM_NUM=16.
  - CNT_W=16.
  - typedef enum com_state_t {OFF, ON_CHK, ON, OFF_CHK}.
  - The count-width constant for oCnt, computed from COM_NUM.
- Sub-module bsk_com_channel: one FSM plus counter. Inputs iClk, iRes, req, force_off; output relay.
  - Instantiated COM_NUM times by a generate loop.
  - The top level holds the synchroniser and the oCnt popcount.

Test Plan (DEB_ON=4, DEB_OFF=3, MIN_ON=10, SYNC_EN defined unless noted):
1. Reset: iRes=0 with any iCom -> oRelay=FFFF, oCnt=0. Assert iRes=0 mid-operation with relays on -> FFFF immediately, before the next edge.
2. Turn-on: iEnable=0, iCom FFFF->FFFE -> oRelay[0]=0 exactly at edge 6 after the change, oCnt=1 at edge 6. Undefine SYNC_EN -> edge 4.
3. Glitch rejection: iCom[1] low for 3 clocks, then high -> oRelay stays FFFF, oCnt=0 throughout.
4. Minimum on-time: channel 0 on at edge E; iCom[0] returns high 2 clocks later -> oRelay[0] stays 0 until edge E+12, then 1.
5. Re-trigger in OFF_CHK: during the release window, iCom[0] goes low again -> relay stays 0, FSM returns to ON; the next release takes 3 samples (no new MIN_ON wait).
6. Safety drop: iCom=0000, all 16 on, oCnt=16; iEnable->1 -> oRelay=FFFF and oCnt=0 at edge 3 after the change, MIN_ON ignored.
